// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with main control decode and load-use hazard detection.
// Optional STALL_COUNTER_EN adds saturating stall_count / flush_count outputs.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] PC_ID,
    input  logic [WIDTH-1:0] IMM_ID,
    input  logic [WIDTH-1:0] REG_DATA1_ID,
    input  logic [WIDTH-1:0] REG_DATA2_ID,
    input  logic [2:0]       FUNCT3_ID,
    input  logic [6:0]       FUNCT7_ID,
    input  logic [6:0]       OPCODE_ID,
    input  logic [4:0]       RD_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
`ifdef STALL_COUNTER_EN
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
`endif
    output logic [WIDTH-1:0] PC_EX,
    output logic [WIDTH-1:0] IMM_EX,
    output logic [WIDTH-1:0] REG_DATA1_EX,
    output logic [WIDTH-1:0] REG_DATA2_EX,
    output logic [2:0]       FUNCT3_EX,
    output logic [6:0]       FUNCT7_EX,
    output logic [4:0]       RD_EX,
    output logic [4:0]       RS1_EX,
    output logic [4:0]       RS2_EX,
    output logic             RegWrite_EX,
    output logic             MemRead_EX,
    output logic             MemWrite_EX,
    output logic             MemtoReg_EX,
    output logic             ALUSrc_EX,
    output logic             Branch_EX,
    output logic [1:0]       ALUOp_EX
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic       reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch;
    logic [1:0] alu_op;
    logic       uses_rs1, uses_rs2;
    logic       hazard, stall, bubble;

    always_comb begin
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b0;
        unique case (OPCODE_ID)
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
                uses_rs2  = 1'b1;
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = 2'b11;
            end
            OP_LD: begin
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
            end
            OP_SD: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_BR: begin
                branch   = 1'b1;
                alu_op   = 2'b01;
                uses_rs2 = 1'b1;
            end
            default: uses_rs1 = 1'b0;
        endcase
    end

    // A flush already discards the dependent instruction, so it overrides the stall.
    assign hazard = MemRead_EX && (RD_EX != 5'd0) &&
                    ((uses_rs1 && RD_EX == RS1_ID) ||
                     (uses_rs2 && RD_EX == RS2_ID));
    assign stall       = hazard && !PCSrc;
    assign bubble      = stall || PCSrc;
    assign PC_write    = !stall;
    assign IF_ID_write = !stall;
    assign IF_ID_flush = PCSrc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_EX        <= '0;
            IMM_EX       <= '0;
            REG_DATA1_EX <= '0;
            REG_DATA2_EX <= '0;
            FUNCT3_EX    <= '0;
            FUNCT7_EX    <= '0;
            RD_EX        <= '0;
            RS1_EX       <= '0;
            RS2_EX       <= '0;
            RegWrite_EX  <= 1'b0;
            MemRead_EX   <= 1'b0;
            MemWrite_EX  <= 1'b0;
            MemtoReg_EX  <= 1'b0;
            ALUSrc_EX    <= 1'b0;
            Branch_EX    <= 1'b0;
            ALUOp_EX     <= 2'b00;
        end else begin
            PC_EX        <= PC_ID;
            IMM_EX       <= IMM_ID;
            REG_DATA1_EX <= REG_DATA1_ID;
            REG_DATA2_EX <= REG_DATA2_ID;
            FUNCT3_EX    <= FUNCT3_ID;
            FUNCT7_EX    <= FUNCT7_ID;
            RS1_EX       <= RS1_ID;
            RS2_EX       <= RS2_ID;
            if (bubble) begin
                RD_EX       <= '0;
                RegWrite_EX <= 1'b0;
                MemRead_EX  <= 1'b0;
                MemWrite_EX <= 1'b0;
                MemtoReg_EX <= 1'b0;
                ALUSrc_EX   <= 1'b0;
                Branch_EX   <= 1'b0;
                ALUOp_EX    <= 2'b00;
            end else begin
                RD_EX       <= RD_ID;
                RegWrite_EX <= reg_write;
                MemRead_EX  <= mem_read;
                MemWrite_EX <= mem_write;
                MemtoReg_EX <= mem_to_reg;
                ALUSrc_EX   <= alu_src;
                Branch_EX   <= branch;
                ALUOp_EX    <= alu_op;
            end
        end
    end

`ifdef STALL_COUNTER_EN
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != '1)
                stall_count <= stall_count + ONE;
            if (PCSrc && flush_count != '1)
                flush_count <= flush_count + ONE;
        end
    end
`else
    if (CNT_W > 0) begin : g_no_counters
    end
`endif

endmodule
